// File: rtl/deserializer_if.sv
// Handshake/bus bundle for the deserializer: serial input side plus FIFO drain side.
interface deserializer_if #(
  parameter int N     = 8,
  parameter int DEPTH = 4
);
  logic                     in;
  logic                     in_valid;
  logic                     sync;
  logic [N-1:0]             out;
  logic                     out_valid;
  logic                     out_ready;
  logic [$clog2(DEPTH):0]   count;
  logic                     overflow;
  logic                     frame_err;
  logic                     clr_flags;

  modport master (
    output in, in_valid, sync, out_ready, clr_flags,
    input  out, out_valid, count, overflow, frame_err
  );

  modport slave (
    input  in, in_valid, sync, out_ready, clr_flags,
    output out, out_valid, count, overflow, frame_err
  );
endinterface

// File: rtl/deserializer.sv
// Serial-to-parallel receiver: LSB-first word assembly aligned on a sync marker,
// feeding a first-word-fall-through FIFO with sticky overflow / framing flags.
module deserializer #(
  parameter int N     = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  deserializer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(N);
  localparam logic [BW-1:0] LAST = BW'(N - 1);

  typedef enum logic {HUNT, ASSEMBLE} state_t;

  state_t         r_state;
  logic [BW-1:0]  r_bit_cnt;
  logic [N-1:0]   r_shift;
  logic [N-1:0]   r_mem [DEPTH];
  logic [AW-1:0]  r_wptr, r_rptr;
  logic [CW-1:0]  r_count;
  logic [N-1:0]   r_last;
  logic           r_ovf, r_ferr;

  logic           w_pop, w_resync, w_done, w_push, w_drop;
  logic [N-1:0]   w_word;

  assign w_pop    = (r_count != '0) && bus.out_ready;
  assign w_resync = bus.in_valid && (r_state == ASSEMBLE) && bus.sync && (r_bit_cnt != '0);
  assign w_done   = bus.in_valid && (r_state == ASSEMBLE) && !w_resync && (r_bit_cnt == LAST);
  assign w_word   = {bus.in, r_shift[N-2:0]};
  // A full FIFO still accepts the word when the head leaves on the same edge.
  assign w_push   = w_done && ((r_count < CW'(DEPTH)) || w_pop);
  assign w_drop   = w_done && !w_push;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= HUNT;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else if (bus.in_valid) begin
      case (r_state)
        HUNT: begin
          if (bus.sync) begin
            r_shift[0] <= bus.in;
            r_bit_cnt  <= BW'(1);
            r_state    <= ASSEMBLE;
          end
        end
        ASSEMBLE: begin
          if (w_resync) begin
            r_shift[0] <= bus.in;
            r_bit_cnt  <= BW'(1);
          end else if (r_bit_cnt == LAST) begin
            r_bit_cnt <= '0;
          end else begin
            r_shift[r_bit_cnt] <= bus.in;
            r_bit_cnt          <= r_bit_cnt + BW'(1);
          end
        end
        default: r_state <= HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_word;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_last  <= '0;
      r_ovf   <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
        r_last <= r_mem[r_rptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      r_ovf  <= (r_ovf  && !bus.clr_flags) || w_drop;
      r_ferr <= (r_ferr && !bus.clr_flags) || w_resync;
    end
  end

  // Empty FIFO keeps showing the most recently popped word.
  assign bus.out       = (r_count != '0) ? r_mem[r_rptr] : r_last;
  assign bus.out_valid = (r_count != '0);
  assign bus.count     = r_count;
  assign bus.overflow  = r_ovf;
  assign bus.frame_err = r_ferr;
endmodule

// File: tb/tb_deserializer.sv
// Bench for deserializer: directed scenarios plus random traffic, checked each
// cycle against a queue-based model of the receive/FIFO behaviour.
module tb_deserializer;
  localparam int N = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;

  deserializer_if #(.N(N), .DEPTH(DEPTH)) bus ();

  deserializer #(.N(N), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // model state
  logic [N-1:0] mq[$];
  logic [N-1:0] m_last;
  logic [N-1:0] m_acc;
  int           m_nb;
  bit           m_hunt;
  bit           m_ovf, m_ferr;
  logic [N-1:0] dpopped[$];
  int           maxcnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_last = '0; m_acc = '0; m_nb = 0; m_hunt = 1;
    m_ovf = 0; m_ferr = 0;
  endtask

  // Compare at negedge, then advance the model by the inputs the next posedge samples.
  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) model_reset();
      chk("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
      chk("out", 32'(bus.out), 32'((mq.size() != 0) ? mq[0] : m_last));
      chk("count", 32'(bus.count), 32'(mq.size()));
      chk("overflow", 32'(bus.overflow), 32'(m_ovf));
      chk("frame_err", 32'(bus.frame_err), 32'(m_ferr));
      if (int'(bus.count) > maxcnt) maxcnt = int'(bus.count);
      if (rst_n) begin
        bit pop, done, fset, oset;
        logic [N-1:0] word;
        pop = (mq.size() != 0) && bus.out_ready;
        done = 0; fset = 0; word = '0;
        if (bus.out_valid && bus.out_ready) dpopped.push_back(bus.out);
        if (bus.in_valid) begin
          if (m_hunt) begin
            if (bus.sync) begin m_hunt = 0; m_acc[0] = bus.in; m_nb = 1; end
          end else if (bus.sync && m_nb != 0) begin
            fset = 1; m_acc[0] = bus.in; m_nb = 1;
          end else begin
            m_acc[m_nb] = bus.in;
            m_nb++;
            if (m_nb == N) begin done = 1; word = m_acc; m_nb = 0; end
          end
        end
        oset = done && !((mq.size() < DEPTH) || pop);
        if (pop) m_last = mq.pop_front();
        if (done && !oset) mq.push_back(word);
        m_ovf  = (m_ovf  && !bus.clr_flags) || oset;
        m_ferr = (m_ferr && !bus.clr_flags) || fset;
      end
    end
  end

  task automatic drive(input logic b, input logic s, input logic v);
    bus.in = b; bus.sync = s; bus.in_valid = v;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 0; bus.sync = 0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_word(input logic [N-1:0] w, input bit s, input bit gaps);
    for (int i = 0; i < N; i++) begin
      if (gaps) idle(int'($urandom_range(0, 2)));
      drive(w[i], s && (i == 0), 1'b1);
    end
    bus.in_valid = 0; bus.sync = 0;
  endtask

  task automatic do_reset();
    #2 rst_n = 0;
    @(posedge clk); @(posedge clk); #3 rst_n = 1;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [N-1:0] exp3 [3];
    logic [N-1:0] w;
    bus.in = 0; bus.in_valid = 0; bus.sync = 0; bus.out_ready = 0; bus.clr_flags = 0;
    #1;
    chk("rst count", 32'(bus.count), 0);
    chk("rst out", 32'(bus.out), 0);
    chk("rst out_valid", 32'(bus.out_valid), 0);
    @(posedge clk); @(posedge clk); #3 rst_n = 1;
    @(posedge clk); #1;

    // 1: basic word
    bus.out_ready = 1;
    send_word(8'hA5, 1, 0);
    chk("t1 out", 32'(bus.out), 32'h A5);
    chk("t1 valid", 32'(bus.out_valid), 1);
    chk("t1 count1", 32'(bus.count), 1);
    idle(1);
    chk("t1 count0", 32'(bus.count), 0);
    chk("t1 valid0", 32'(bus.out_valid), 0);
    chk("t1 hold", 32'(bus.out), 32'h A5);
    chk("t1 flags", 32'({bus.overflow, bus.frame_err}), 0);

    // 2: pre-sync bits ignored
    do_reset();
    dpopped.delete(); maxcnt = 0;
    for (int i = 0; i < 3; i++) drive(1'($urandom), 0, 1);
    send_word(8'h3C, 1, 0);
    idle(2);
    chk("t2 npop", 32'(dpopped.size()), 1);
    if (dpopped.size() > 0) chk("t2 word", 32'(dpopped[0]), 32'h3C);
    chk("t2 maxcnt", 32'(maxcnt), 1);

    // 3: stream + ordering
    do_reset();
    bus.out_ready = 0;
    exp3[0] = 8'h01; exp3[1] = 8'h80; exp3[2] = 8'hFF;
    for (int i = 0; i < 3; i++) send_word(exp3[i], i == 0, 1);
    idle(1);
    chk("t3 count", 32'(bus.count), 3);
    dpopped.delete();
    bus.out_ready = 1;
    repeat (3) begin @(posedge clk); #1; end
    bus.out_ready = 0;
    chk("t3 npop", 32'(dpopped.size()), 3);
    for (int i = 0; i < 3 && i < dpopped.size(); i++) chk("t3 order", 32'(dpopped[i]), 32'(exp3[i]));
    chk("t3 empty", 32'(bus.count), 0);

    // 4: overflow
    do_reset();
    for (int i = 1; i <= 5; i++) begin w = 8'(i * 8'h11); send_word(w, i == 1, 0); end
    idle(1);
    chk("t4 count", 32'(bus.count), 4);
    chk("t4 ovf", 32'(bus.overflow), 1);
    dpopped.delete();
    bus.out_ready = 1; idle(4); bus.out_ready = 0;
    chk("t4 npop", 32'(dpopped.size()), 4);
    for (int i = 0; i < 4 && i < dpopped.size(); i++) chk("t4 drain", 32'(dpopped[i]), 32'((i + 1) * 8'h11));
    bus.clr_flags = 1; idle(1); bus.clr_flags = 0;
    chk("t4 clr", 32'(bus.overflow), 0);
    do_reset();
    for (int i = 1; i <= 4; i++) begin w = 8'(i * 8'h11); send_word(w, i == 1, 0); end
    for (int i = 0; i < 7; i++) drive(w[i] ^ 1'b0 ? 8'h55 >> i : 8'h55 >> i, 0, 1);
    bus.out_ready = 1;
    drive(1'b0, 0, 1);
    bus.out_ready = 0; bus.in_valid = 0;
    chk("t4b ovf", 32'(bus.overflow), 0);
    chk("t4b count", 32'(bus.count), 4);
    dpopped.delete();
    bus.out_ready = 1; idle(4); bus.out_ready = 0;
    chk("t4b npop", 32'(dpopped.size()), 4);
    if (dpopped.size() == 4) chk("t4b last", 32'(dpopped[3]), 32'h55);

    // 5: mid-word resync
    do_reset();
    bus.out_ready = 1; dpopped.delete();
    drive(1, 1, 1); drive(0, 0, 1); drive(1, 0, 1);
    send_word(8'hC3, 1, 0);
    idle(2);
    chk("t5 ferr", 32'(bus.frame_err), 1);
    chk("t5 npop", 32'(dpopped.size()), 1);
    if (dpopped.size() > 0) chk("t5 word", 32'(dpopped[0]), 32'hC3);
    bus.clr_flags = 1; idle(1); bus.clr_flags = 0;
    chk("t5 clr", 32'(bus.frame_err), 0);
    drive(1, 0, 1); drive(0, 0, 1); drive(1, 0, 1);
    bus.clr_flags = 1; drive(1, 1, 1); bus.clr_flags = 0;
    idle(1);
    chk("t5 set+clr", 32'(bus.frame_err), 1);

    // 6: reset mid-operation
    do_reset();
    bus.out_ready = 0;
    send_word(8'h5A, 1, 0); send_word(8'h96, 0, 0);
    for (int i = 0; i < 4; i++) drive(1, 0, 1);
    bus.in_valid = 0;
    chk("t6 count2", 32'(bus.count), 2);
    #2 rst_n = 0; #1;
    chk("t6 valid", 32'(bus.out_valid), 0);
    chk("t6 count", 32'(bus.count), 0);
    chk("t6 out", 32'(bus.out), 0);
    @(posedge clk); @(posedge clk); #3 rst_n = 1;
    @(posedge clk); #1;
    bus.out_ready = 1; dpopped.delete();
    send_word(8'hFF, 0, 0);
    idle(3);
    chk("t6 nopush", 32'(bus.count), 0);
    chk("t6 npop", 32'(dpopped.size()), 0);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      bus.in        = 1'($urandom);
      bus.in_valid  = ($urandom % 4) != 0;
      bus.sync      = ($urandom % 12) == 0;
      bus.out_ready = ($urandom % 3) != 0;
      bus.clr_flags = ($urandom % 40) == 0;
      @(posedge clk); #1;
    end
    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/deserializer.md
# deserializer

Serial-to-parallel receive stage, the counterpart of the N-bit transmit serializer. Samples a qualified serial bit stream LSB-first, locks word alignment to a sync marker, and assembles N-bit words. Completed words go into a small first-word-fall-through FIFO that drains over a valid/ready handshake. Sticky overflow and framing-error flags report lost data.

## Interface

**Parameters**

- `N`, default 8: word width in bits; must be ≥ 2.
- `DEPTH`, default 4: output FIFO depth in words; a power of 2 and ≥ 2.

**Ports**

- `clk`  in  1  single clock; everything is sampled on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in`  in  1  serial data bit.
- `in_valid`  in  1  `in` (and `sync`) carry a bit this cycle.
- `sync`  in  1  the current bit is bit 0 of a word; meaningful only with `in_valid`.
- `out`  out  N  word at the FIFO head.
- `out_valid`  out  1  FIFO not empty.
- `out_ready`  in  1  consumer accepts `out` this cycle.
- `count`  out  clog2(DEPTH)+1  FIFO fill level, 0..DEPTH.
- `overflow`  out  1  sticky: a completed word was dropped.
- `frame_err`  out  1  sticky: `sync` arrived mid-word.
- `clr_flags`  in  1  single-cycle pulse that clears `overflow` and `frame_err`.

## Operation

- **State HUNT** (entered at reset):
  - Bits are ignored until `in_valid && sync`.
  - That bit is stored as bit 0, `bit_cnt` = 1, and the block moves to ASSEMBLE.
- **State ASSEMBLE**, on each `in_valid`:
  - Normal bit: `shift[bit_cnt]` = `in`, then `bit_cnt` increments.
  - `sync` with `bit_cnt` = 0: normal (an aligned resync).
  - `sync` with `bit_cnt` ≠ 0: the partial word is discarded and `frame_err` is set. The current bit is stored as bit 0 and `bit_cnt` = 1.
  - Bit with `bit_cnt` = N-1: the word is complete. `{in, shift[N-2:0]}` is pushed and `bit_cnt` wraps to 0. The block stays in ASSEMBLE, so a continuous stream needs no further sync.
- When `in_valid` = 0, `bit_cnt`, state and shift register hold. `sync` is ignored.
- **Push rules:**
  - The push is accepted if `count` < DEPTH, or if a pop happens in the same cycle.
  - Otherwise the word is dropped and `overflow` is set. FIFO contents are unchanged.
- **Pop:** occurs when `out_valid && out_ready`.
- **Simultaneous push and pop:**
  - `count` is unchanged.
  - When empty, no push/pop interaction occurs, because `out_valid` was 0.
- **Flags:** setting and clearing in the same cycle leaves the flag set. Flags do not affect data flow.
- **`out` contents:** `out` = FIFO head. When empty, `out` holds its last value (0 after reset).
- **Pointers:** read and write pointers are clog2(DEPTH) bits and wrap modulo DEPTH. `count` is tracked separately.

## Timing

- **Reset values:** `out` = 0, `out_valid` = 0, `count` = 0, `overflow` = 0, `frame_err` = 0. Internally, state = HUNT, `bit_cnt` = 0, pointers = 0.
- **Async reset:** outputs go to their reset values immediately on `reset` falling, with no clock needed. Reset mid-word or with the FIFO non-empty discards all data.
- **Latency:** the last bit of a word is sampled at edge k. Into an empty FIFO, `out`/`out_valid` reflect that word after edge k, i.e. usable at edge k+1.
- **Throughput:** one bit per cycle. A word every N `in_valid` cycles, with arbitrary gaps.
- **Handshake:**
  - `out` is stable while `out_valid && !out_ready`.
  - After a pop at edge m, the next word (if any) is presented after edge m.
  - `count` updates at the same edge as the push/pop.
- **Flag timing:** `overflow` and `frame_err` assert after the edge that samples the offending bit.

## Test plan

1. **Basic word.** Reset, `out_ready` = 1. Drive 0xA5 LSB-first (bits 1,0,1,0,0,1,0,1), with `sync` on the first bit.
   - Required: `out` = 0xA5 and `out_valid` = 1 for exactly one cycle after the 8th bit. `count` goes 0→1→0. Flags stay 0.
2. **Pre-sync bits ignored.** Three random bits with `sync` = 0, then a synced 0x3C.
   - Required: only 0x3C appears. `count` never exceeds 1.
3. **Continuous stream and ordering.** `out_ready` = 0. Send 0x01, 0x80, 0xFF with random `in_valid` gaps and `sync` only on the first word.
   - Required: `count` = 3. Then `out_ready` = 1 yields 0x01, 0x80, 0xFF in order, one per cycle.
4. **Overflow.** DEPTH = 4, `out_ready` = 0. Send 5 words 0x11..0x55.
   - Required: `count` = 4, `overflow` = 1 after the 5th word. Drain yields 0x11..0x44.
   - Pulse `clr_flags` → `overflow` = 0.
   - Repeat with `out_ready` = 1 exactly on the 5th word's last-bit cycle: no overflow, 0x55 retained.
5. **Mid-word resync.** Send 3 bits, then `sync` with 8 bits of 0xC3.
   - Required: `frame_err` = 1, output is exactly 0xC3. `clr_flags` together with a new mid-word sync leaves `frame_err` = 1.
6. **Reset mid-operation.** 2 words in the FIFO plus 4 bits of a third; assert `reset` between edges.
   - Required: `out_valid` = 0, `count` = 0, `out` = 0 immediately.
   - After release, bits without `sync` produce nothing.
